// File: rtl/nios_system_group_id_checker.sv
// nios_system_group_id_checker: reads ID/timestamp words from an upstream slave, retries on mismatch, reports via status and irq.
// Define GROUP_ID_CHECK_TS_EN to include the timestamp read and compare.
module nios_system_group_id_checker #(
  parameter logic [31:0] EXPECTED_ID = 32'd0,
  parameter logic [31:0] EXPECTED_TS = 32'd1537299572,
  parameter int unsigned RETRY_MAX   = 3,
  parameter int unsigned WAIT_MAX    = 255
) (
  input  logic        clock,
  input  logic        reset,
  output logic        m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);
`ifdef GROUP_ID_CHECK_TS_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, PASS, FAIL} state_t;
  state_t      state, state_n;
  logic [31:0] id_q, ts_q;
  logic        mismatch, timeout;
  logic [3:0]  attempt;
  logic [15:0] wait_cnt;
  logic        ack, expired, match, retry, done, restart;
  logic        unused;
  assign unused     = ^{s_read, s_writedata};
  assign m_read     = state == RD_ID || state == RD_TS;
  assign m_address  = state == RD_TS;
  assign irq        = state == FAIL;
  assign done       = state == PASS || state == FAIL;
  assign ack        = m_read && !m_waitrequest;
  assign expired    = m_read && m_waitrequest && wait_cnt == 16'(WAIT_MAX - 1);
  assign match      = id_q == EXPECTED_ID && (!TS_EN || ts_q == EXPECTED_TS);
  assign retry      = attempt < 4'(RETRY_MAX);
  assign restart    = s_write && s_address == 2'd3 && done;
  assign s_readdata = s_address == 2'd0 ? {20'd0, attempt, 4'd0, timeout, mismatch, state == PASS, done}
                    : s_address == 2'd1 ? id_q
                    : (s_address == 2'd2 && TS_EN) ? ts_q : '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = RD_ID;
      RD_ID:   state_n = expired ? FAIL : ack ? (TS_EN ? RD_TS : CHECK) : RD_ID;
      RD_TS:   state_n = expired ? FAIL : ack ? CHECK : RD_TS;
      CHECK:   state_n = match ? PASS : retry ? IDLE : FAIL;
      default: state_n = restart ? IDLE : state;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      id_q     <= '0;
      ts_q     <= '0;
      mismatch <= 1'b0;
      timeout  <= 1'b0;
      attempt  <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= (m_read && m_waitrequest) ? wait_cnt + 16'd1 : '0;
      if (state == RD_ID && ack) id_q <= m_readdata;
      if (state == RD_TS && ack) ts_q <= m_readdata;
      if (expired) timeout <= 1'b1;
      if (state == CHECK && !match) begin
        mismatch <= 1'b1;
        if (retry && attempt != 4'hf) attempt <= attempt + 4'd1;
      end
      if (restart) begin
        mismatch <= 1'b0;
        timeout  <= 1'b0;
        attempt  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_nios_system_group_id_checker.sv
// tb_nios_system_group_id_checker: vector table, hand-written corner sequences and randomized runs against an outcome-level model.
module tb_nios_system_group_id_checker;
`ifdef GROUP_ID_CHECK_TS_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1537299572;
  localparam int RETRY_MAX = 3;
  localparam int WAIT_MAX  = 8;
  localparam int RD        = TS_EN ? 2 : 1;
  localparam logic [31:0] ST_PASS = 32'h003;
  localparam logic [31:0] ST_FAIL = 32'h005 | (RETRY_MAX << 8);

  logic clk = 1'b0, rst = 1'b1;
  logic m_address, m_read, m_waitrequest, irq;
  logic [31:0] m_readdata, s_readdata;
  logic [1:0] s_address = 2'd0;
  logic s_read = 1'b0, s_write = 1'b0;
  logic [31:0] s_writedata = 32'd0;
  logic [31:0] slv_id = EXP_ID, slv_ts = EXP_TS;
  logic stall_all = 1'b0, stall_last = 1'b0, rnd_en = 1'b0, rnd_stall = 1'b0;
  int consec = 0, n_reads = 0, tests = 0, fails = 0;
  logic addr1_seen = 1'b0;

  nios_system_group_id_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .RETRY_MAX(RETRY_MAX), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clock(clk), .reset(rst), .m_address(m_address), .m_read(m_read),
    .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_readdata(s_readdata), .irq(irq)
  );

  always #10 clk = ~clk;

  assign m_readdata    = m_address ? slv_ts : slv_id;
  assign m_waitrequest = m_read && (rnd_stall || stall_all || (stall_last && m_address == TS_EN));

  always @(posedge clk) begin
    consec <= (m_read && m_waitrequest) ? consec + 1 : 0;
    if (!rst && m_read && !m_waitrequest) n_reads <= n_reads + 1;
    if (m_address) addr1_seen <= 1'b1;
  end
  always @(negedge clk) rnd_stall = rnd_en && consec < WAIT_MAX - 2 && $urandom_range(0, 2) == 0;

  typedef struct {
    logic [31:0] id, ts, status;
    logic        irq;
    int          reads;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    s_address = a;
    #1 v = s_readdata;
  endtask

  task automatic wait_done(input int lim, output int n);
    logic [31:0] st;
    n = 0;
    st = 32'd0;
    while (n < lim && !st[0]) begin
      @(negedge clk);
      n++;
      rd(2'd0, st);
    end
    if (!st[0]) chk("done_timeout", 32'(n), 32'(lim + 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic restart();
    logic [31:0] v;
    @(negedge clk);
    s_write = 1'b1;
    s_address = 2'd3;
    @(negedge clk);
    s_write = 1'b0;
    chk("restart_irq", 32'(irq), 32'd0);
    rd(2'd0, v);
    chk("restart_status", v, 32'd0);
  endtask

  initial begin
    logic [31:0] v, exp_st;
    int n, r0, stalls, bad_addr;
    bit ok;
    tbl[0] = '{EXP_ID,        EXP_TS,         ST_PASS,                     1'b0,          RD};
    tbl[1] = '{32'd5,         EXP_TS,         ST_FAIL,                     1'b1,          4 * RD};
    tbl[2] = '{EXP_ID,        32'd1234,       TS_EN ? ST_FAIL : ST_PASS,   TS_EN,         TS_EN ? 4 * RD : RD};
    tbl[3] = '{EXP_ID,        EXP_TS ^ 32'd1, TS_EN ? ST_FAIL : ST_PASS,   TS_EN,         TS_EN ? 4 * RD : RD};
    tbl[4] = '{32'hffff_ffff, 32'd0,          ST_FAIL,                     1'b1,          4 * RD};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_m_read", 32'(m_read), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rd(2'd0, v); chk("rst_status", v, 32'd0);
    rd(2'd1, v); chk("rst_id", v, 32'd0);
    rd(2'd2, v); chk("rst_ts", v, 32'd0);
    rst = 1'b0;
    wait_done(50, n);
    chk("pass_latency", 32'(n), TS_EN ? 32'd4 : 32'd3);

    for (int i = 0; i < 5; i++) begin
      slv_id = tbl[i].id;
      slv_ts = tbl[i].ts;
      do_reset();
      r0 = n_reads;
      wait_done(200, n);
      rd(2'd0, v); chk($sformatf("vec%0d_status", i), v, tbl[i].status);
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(tbl[i].irq));
      rd(2'd1, v); chk($sformatf("vec%0d_id", i), v, tbl[i].id);
      rd(2'd2, v); chk($sformatf("vec%0d_ts", i), v, TS_EN ? tbl[i].ts : 32'd0);
      chk($sformatf("vec%0d_reads", i), 32'(n_reads - r0), 32'(tbl[i].reads));
    end

    // reset during a stalled ID read discards the earlier captures
    stall_all = 1'b1;
    restart();
    repeat (3) @(negedge clk);
    chk("stall_m_read", 32'(m_read), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_m_read", 32'(m_read), 32'd0);
    rd(2'd1, v); chk("midrst_id", v, 32'd0);
    rd(2'd0, v); chk("midrst_status", v, 32'd0);
    stall_all = 1'b0;
    slv_id = EXP_ID;
    slv_ts = EXP_TS;
    @(negedge clk);
    rst = 1'b0;
    wait_done(50, n);
    chk("midrst_latency", 32'(n), TS_EN ? 32'd4 : 32'd3);
    rd(2'd0, v); chk("midrst_pass", v, ST_PASS);

    // timeout on the last read of the sequence
    stall_last = 1'b1;
    do_reset();
    n = 0; stalls = 0; bad_addr = 0; v = 32'd0;
    while (n < 100 && !v[0]) begin
      @(negedge clk);
      n++;
      if (m_read && m_waitrequest) begin
        stalls++;
        if (m_address != TS_EN) bad_addr++;
      end
      rd(2'd0, v);
    end
    stall_last = 1'b0;
    chk("to_stalls", 32'(stalls), WAIT_MAX);
    chk("to_addr_stable", 32'(bad_addr), 32'd0);
    chk("to_status", v, 32'h009);
    chk("to_irq", 32'(irq), 32'd1);

    // restart from FAIL, then a restart write during RD_ID is ignored
    restart();
    wait_done(50, n);
    rd(2'd0, v); chk("rs_fail_pass", v, ST_PASS);
    stall_all = 1'b1;
    do_reset();
    @(negedge clk);
    s_write = 1'b1;
    s_address = 2'd3;
    @(negedge clk);
    s_write = 1'b0;
    chk("ign_m_read", 32'(m_read), 32'd1);
    chk("ign_m_addr", 32'(m_address), 32'd0);
    stall_all = 1'b0;
    wait_done(50, n);
    rd(2'd0, v); chk("ign_pass", v, ST_PASS);
    restart();
    wait_done(50, n);
    rd(2'd0, v); chk("rs_pass_pass", v, ST_PASS);

    // randomized slave words and stalls
    rnd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      slv_id = $urandom_range(0, 1) ? EXP_ID : $urandom;
      slv_ts = $urandom_range(0, 1) ? EXP_TS : $urandom;
      ok = slv_id == EXP_ID && (!TS_EN || slv_ts == EXP_TS);
      exp_st = ok ? 32'h003 : 32'h005 | (RETRY_MAX << 8);
      restart();
      r0 = n_reads;
      wait_done(400, n);
      rd(2'd0, v); chk($sformatf("rnd%0d_status", i), v, exp_st);
      rd(2'd1, v); chk($sformatf("rnd%0d_id", i), v, slv_id);
      rd(2'd2, v); chk($sformatf("rnd%0d_ts", i), v, TS_EN ? slv_ts : 32'd0);
      chk($sformatf("rnd%0d_reads", i), 32'(n_reads - r0), 32'((ok ? 1 : RETRY_MAX + 1) * RD));
    end
    rnd_en = 1'b0;

    chk("addr1_seen", 32'(addr1_seen), 32'(TS_EN));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
